display_scan_ctrl: RTL and testbench
====================================

Name: display_scan_ctrl

Overview:
- Time-multiplexes NUM_DIGITS 4-bit digit values onto one shared decoder input (dec_data), so one decoder serves several display positions.
- Drives a one-hot digit enable and inserts a blanking gap between digits to suppress ghosting.
- Double-buffers the displayed values so a new value is applied only at a frame boundary.
- Sits between the register or CPU side and the shared decoder plus display driver.

Parameters:
- NUM_DIGITS, 4, number of display positions sharing the decoder (2..8).
- PRESCALE, 50000, clk cycles each digit is shown (>=1).
- BLANK_CYCLES, 16, clk cycles with all digits off between slots (>=0).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  1 = scanning, 0 = display off.
- load  input  1  single-cycle strobe to capture value.
- value  input  4*NUM_DIGITS  digit values; digit i = value[4i+3:4i].
- dec_data  output  4  nibble presented to the shared decoder.
- digit_en  output  NUM_DIGITS  one-hot digit enable, active-high.
- digit_idx  output  $clog2(NUM_DIGITS)  index of the current or last digit.
- frame_done  output  1  one-cycle pulse when the last digit's slot (incl. blank) ends.

Behaviour:
- All outputs registered. Reset state: state=IDLE, dec_data=0, digit_en=0, digit_idx=0, frame_done=0, pending buffer=0, active buffer=0, slot counter=0.
- States: IDLE, SHOW, BLANK.
- IDLE:
  - Outputs zero.
  - enable=1 -> SHOW with idx=0 next cycle; active<=pending on the same edge.
- SHOW:
  - digit_en=onehot(idx), dec_data=active[idx]; lasts exactly PRESCALE cycles.
  - If BLANK_CYCLES>0, then BLANK.
  - If BLANK_CYCLES=0, advance idx directly into the next SHOW (no gap cycle).
- BLANK:
  - digit_en=0, dec_data holds its last value; lasts exactly BLANK_CYCLES cycles.
  - Then idx advances and returns to SHOW.
- Index advance:
  - idx increments; at NUM_DIGITS-1 it wraps to 0.
  - On wrap: frame_done=1 for one cycle, concurrent with the first cycle of the idx-0 SHOW, and active<=pending on the same edge.
- Load handling:
  - load=1 -> pending<=value next edge, in any state.
  - In IDLE, active also updates on that edge.
  - During scanning, the value is visible only from the next frame.
- Simultaneous load and wrap edge: the loaded value goes directly into active and is shown in the frame starting that cycle.
- enable dropped in any state: IDLE next cycle, all outputs 0, idx and counter cleared. Pending is kept.
- rst asserted mid-frame: same as the reset state on the next edge, overriding enable and load.
- Slot counter width: $clog2(max(PRESCALE,BLANK_CYCLES)+1). The counter clears on every state change.
- Period: one frame = NUM_DIGITS*(PRESCALE+BLANK_CYCLES) cycles.

Decomposition:
- display_pkg holds:
  - scan_state_t enum {IDLE, SHOW, BLANK}
  - function onehot(idx, width)
  - localparam NIBBLE_W=4
- One sub-module, scan_slot_timer:
  - Loadable down-counter with a terminal-count flag.
  - Instantiated once; reloaded with PRESCALE or BLANK_CYCLES at state entry.
- Buffers, FSM and index logic stay in the top module.

Test Plan:
- Bench parameters: NUM_DIGITS=4, PRESCALE=3, BLANK_CYCLES=1.
- Reset then enable=1 with value preloaded in IDLE to 16'h4C81 -> dec_data sequence 1,8,C,4. digit_en 0001,0010,0100,1000, each for 3 cycles separated by 1 cycle of 0000. frame_done pulses every 16 cycles.
- load 16'hFFFF mid-frame at digit 1 -> the rest of this frame still shows 8,C,4. The next frame shows F on all digits.
- load asserted on the exact wrap edge -> the new value appears in digit 0 of that frame, with frame_done=1 in the same cycle.
- enable=0 during BLANK of digit 2 -> next cycle digit_en=0, dec_data=0, digit_idx=0. Re-enable restarts at digit 0 with the pending value.
- rst=1 during SHOW of digit 3 with enable=1 -> all outputs 0 next edge. After release, scanning restarts at digit 0 showing 0.
- Re-parameterise BLANK_CYCLES=0 -> digit_en moves 0001->0010 with no zero gap. Frame is 12 cycles.

Source files
------------

// File: rtl/display_pkg.sv
// Shared types and helpers for the multiplexed display scan controller.
package display_pkg;

  localparam int unsigned NIBBLE_W   = 4;
  localparam int unsigned MAX_DIGITS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    BLANK = 2'd2
  } scan_state_t;

  // Bits at or above width stay clear so the caller can safely truncate.
  function automatic logic [MAX_DIGITS-1:0] onehot(input int unsigned idx,
                                                   input int unsigned width);
    logic [MAX_DIGITS-1:0] oh;
    oh = '0;
    for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
      oh[i] = (i == idx) && (i < width);
    end
    return oh;
  endfunction

endpackage

// File: rtl/display_scan_ctrl_if.sv
// Register-side controls and decoder-side outputs of the display scan controller.
interface display_scan_ctrl_if #(
  parameter int unsigned NUM_DIGITS = 4
) ();
  import display_pkg::*;

  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);

  logic                           enable;
  logic                           load;
  logic [NIBBLE_W*NUM_DIGITS-1:0] value;
  logic [NIBBLE_W-1:0]            dec_data;
  logic [NUM_DIGITS-1:0]          digit_en;
  logic [IDX_W-1:0]               digit_idx;
  logic                           frame_done;

  modport master (
    output enable, load, value,
    input  dec_data, digit_en, digit_idx, frame_done
  );

  modport slave (
    input  enable, load, value,
    output dec_data, digit_en, digit_idx, frame_done
  );

endinterface

// File: rtl/scan_slot_timer.sv
// Loadable down-counter timing one display slot; tc is high while the count is zero.
module scan_slot_timer #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             tc
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign tc = (cnt_q == '0);

endmodule

// File: rtl/display_scan_ctrl.sv
// Scans double-buffered digit nibbles onto one shared decoder with a blanking gap per slot.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned PRESCALE     = 50000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input logic               clk,
  input logic               rst,
  display_scan_ctrl_if.slave bus
);

  localparam int unsigned IDX_W   = $clog2(NUM_DIGITS);
  localparam int unsigned VAL_W   = NIBBLE_W * NUM_DIGITS;
  localparam int unsigned MAX_DUR = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_DUR + 1);
  localparam bit          HAS_BLANK = (BLANK_CYCLES > 0);

  localparam logic [CNT_W-1:0] SHOW_LOAD  = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] BLANK_LOAD = HAS_BLANK ? CNT_W'(BLANK_CYCLES - 1) : '0;
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);

  scan_state_t           st_q, st_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [VAL_W-1:0]      pending_q, pending_d;
  logic [VAL_W-1:0]      active_q, active_d;
  logic [NIBBLE_W-1:0]   dec_data_q, dec_data_d;
  logic [NUM_DIGITS-1:0] digit_en_q, digit_en_d;
  logic                  frame_done_q, frame_done_d;
  logic                  tmr_load, tmr_tc, advance;
  logic [CNT_W-1:0]      tmr_val;
  logic [MAX_DIGITS-1:0] oh_full;

  scan_slot_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tc       (tmr_tc)
  );

  always_comb begin
    st_d         = st_q;
    idx_d        = idx_q;
    pending_d    = bus.load ? bus.value : pending_q;
    active_d     = active_q;
    frame_done_d = 1'b0;
    tmr_load     = 1'b0;
    tmr_val      = '0;
    advance      = 1'b0;

    if (!bus.enable) begin
      st_d     = IDLE;
      idx_d    = '0;
      tmr_load = 1'b1;
      if (st_q == IDLE) active_d = pending_d;
    end else begin
      unique case (st_q)
        IDLE: begin
          st_d     = SHOW;
          idx_d    = '0;
          active_d = pending_d;
          tmr_load = 1'b1;
          tmr_val  = SHOW_LOAD;
        end
        SHOW: begin
          if (tmr_tc) begin
            if (HAS_BLANK) begin
              st_d     = BLANK;
              tmr_load = 1'b1;
              tmr_val  = BLANK_LOAD;
            end else begin
              advance = 1'b1;
            end
          end
        end
        BLANK: advance = tmr_tc;
        default: st_d = IDLE;
      endcase
    end

    // A wrap starts a new frame, so the pending buffer (incl. a same-edge load) goes live.
    if (advance) begin
      st_d     = SHOW;
      tmr_load = 1'b1;
      tmr_val  = SHOW_LOAD;
      if (idx_q == LAST_IDX) begin
        idx_d        = '0;
        frame_done_d = 1'b1;
        active_d     = pending_d;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end

    oh_full    = onehot(32'(idx_d), NUM_DIGITS);
    digit_en_d = '0;
    dec_data_d = '0;
    case (st_d)
      SHOW: begin
        digit_en_d = oh_full[NUM_DIGITS-1:0];
        dec_data_d = active_d[NIBBLE_W*int'(idx_d) +: NIBBLE_W];
      end
      BLANK:   dec_data_d = dec_data_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q         <= IDLE;
      idx_q        <= '0;
      pending_q    <= '0;
      active_q     <= '0;
      dec_data_q   <= '0;
      digit_en_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      st_q         <= st_d;
      idx_q        <= idx_d;
      pending_q    <= pending_d;
      active_q     <= active_d;
      dec_data_q   <= dec_data_d;
      digit_en_q   <= digit_en_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.dec_data   = dec_data_q;
  assign bus.digit_en   = digit_en_q;
  assign bus.digit_idx  = idx_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl: one instance with a blank gap, one without.
module tb_display_scan_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a;
  logic rst_b;
  int   n_assert = 0;
  int   n_fail   = 0;

  display_scan_ctrl_if #(.NUM_DIGITS(4)) bus_a ();
  display_scan_ctrl_if #(.NUM_DIGITS(4)) bus_b ();

  display_scan_ctrl #(
    .NUM_DIGITS   (4),
    .PRESCALE     (3),
    .BLANK_CYCLES (1)
  ) dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (bus_a)
  );

  display_scan_ctrl #(
    .NUM_DIGITS   (4),
    .PRESCALE     (3),
    .BLANK_CYCLES (0)
  ) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (bus_b)
  );

  // Advance one clock and compare {digit_en, dec_data, digit_idx, frame_done}.
  task automatic cyc(input bit use_b, input string tag, input logic [3:0] en,
                     input logic [3:0] dec, input logic [1:0] idx, input logic fd);
    logic [10:0] obs;
    logic [10:0] exp_v;
    @(posedge clk);
    #1;
    if (use_b) obs = {bus_b.digit_en, bus_b.dec_data, bus_b.digit_idx, bus_b.frame_done};
    else       obs = {bus_a.digit_en, bus_a.dec_data, bus_a.digit_idx, bus_a.frame_done};
    exp_v = {en, dec, idx, fd};
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: en/dec/idx/fd observed %b/%h/%0d/%b expected %b/%h/%0d/%b",
             tag, obs[10:7], obs[6:3], obs[2:1], obs[0], en, dec, idx, fd);
    end
  endtask

  // Three SHOW cycles of digit d, then `blank` blanking cycles holding the nibble.
  task automatic slot(input bit use_b, input string tag, input logic [1:0] d,
                      input logic [3:0] nib, input bit fd, input int blank);
    logic [3:0] en;
    en = 4'b0001 << d;
    for (int p = 0; p < 3; p++) cyc(use_b, tag, en, nib, d, fd && (p == 0));
    for (int b = 0; b < blank; b++) cyc(use_b, {tag, "_blank"}, 4'b0000, nib, d, 1'b0);
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    bus_a.enable = 1'b0; bus_a.load = 1'b0; bus_a.value = '0;
    bus_b.enable = 1'b0; bus_b.load = 1'b0; bus_b.value = '0;

    @(posedge clk);
    cyc(0, "in_reset", 4'b0000, 4'h0, 2'd0, 1'b0);
    rst_a = 1'b0;
    rst_b = 1'b0;
    cyc(0, "idle_after_reset", 4'b0000, 4'h0, 2'd0, 1'b0);

    // Preload while idle, then start scanning.
    bus_a.value = 16'h4C81;
    bus_a.load  = 1'b1;
    cyc(0, "idle_load", 4'b0000, 4'h0, 2'd0, 1'b0);
    bus_a.load   = 1'b0;
    bus_a.enable = 1'b1;

    slot(0, "f1_d0", 2'd0, 4'h1, 1'b0, 1);
    slot(0, "f1_d1", 2'd1, 4'h8, 1'b0, 1);
    slot(0, "f1_d2", 2'd2, 4'hC, 1'b0, 1);
    slot(0, "f1_d3", 2'd3, 4'h4, 1'b0, 1);

    // Load mid-frame: current frame keeps old values.
    slot(0, "f2_d0", 2'd0, 4'h1, 1'b1, 1);
    cyc(0, "f2_d1_a", 4'b0010, 4'h8, 2'd1, 1'b0);
    bus_a.value = 16'hFFFF;
    bus_a.load  = 1'b1;
    cyc(0, "f2_d1_b", 4'b0010, 4'h8, 2'd1, 1'b0);
    bus_a.load = 1'b0;
    cyc(0, "f2_d1_c", 4'b0010, 4'h8, 2'd1, 1'b0);
    cyc(0, "f2_d1_blank", 4'b0000, 4'h8, 2'd1, 1'b0);
    slot(0, "f2_d2", 2'd2, 4'hC, 1'b0, 1);
    slot(0, "f2_d3", 2'd3, 4'h4, 1'b0, 1);

    // New value visible from the next frame; then load on the exact wrap edge.
    slot(0, "f3_d0", 2'd0, 4'hF, 1'b1, 1);
    slot(0, "f3_d1", 2'd1, 4'hF, 1'b0, 1);
    slot(0, "f3_d2", 2'd2, 4'hF, 1'b0, 1);
    slot(0, "f3_d3", 2'd3, 4'hF, 1'b0, 1);
    bus_a.value = 16'h1234;
    bus_a.load  = 1'b1;
    cyc(0, "wrap_load_d0", 4'b0001, 4'h4, 2'd0, 1'b1);
    bus_a.load = 1'b0;
    cyc(0, "f4_d0_b", 4'b0001, 4'h4, 2'd0, 1'b0);
    cyc(0, "f4_d0_c", 4'b0001, 4'h4, 2'd0, 1'b0);
    cyc(0, "f4_d0_blank", 4'b0000, 4'h4, 2'd0, 1'b0);
    slot(0, "f4_d1", 2'd1, 4'h3, 1'b0, 1);
    slot(0, "f4_d2", 2'd2, 4'h2, 1'b0, 1);

    // Drop enable during BLANK of digit 2.
    bus_a.enable = 1'b0;
    cyc(0, "disable", 4'b0000, 4'h0, 2'd0, 1'b0);
    cyc(0, "disable_hold", 4'b0000, 4'h0, 2'd0, 1'b0);
    bus_a.enable = 1'b1;
    slot(0, "reen_d0", 2'd0, 4'h4, 1'b0, 1);
    slot(0, "reen_d1", 2'd1, 4'h3, 1'b0, 1);
    slot(0, "reen_d2", 2'd2, 4'h2, 1'b0, 1);

    // Reset during SHOW of digit 3 with enable held high.
    cyc(0, "reen_d3", 4'b1000, 4'h1, 2'd3, 1'b0);
    rst_a = 1'b1;
    cyc(0, "rst_mid", 4'b0000, 4'h0, 2'd0, 1'b0);
    rst_a = 1'b0;
    slot(0, "post_rst_d0", 2'd0, 4'h0, 1'b0, 1);

    // No-blank instance: digits abut and the frame is 12 cycles.
    bus_b.value = 16'h4C81;
    bus_b.load  = 1'b1;
    cyc(1, "b_idle_load", 4'b0000, 4'h0, 2'd0, 1'b0);
    bus_b.load   = 1'b0;
    bus_b.enable = 1'b1;
    slot(1, "b_d0", 2'd0, 4'h1, 1'b0, 0);
    slot(1, "b_d1", 2'd1, 4'h8, 1'b0, 0);
    slot(1, "b_d2", 2'd2, 4'hC, 1'b0, 0);
    slot(1, "b_d3", 2'd3, 4'h4, 1'b0, 0);
    slot(1, "b_wrap_d0", 2'd0, 4'h1, 1'b1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
